// File: rtl/pool_layer.sv
// Windowed average/max pooling over a sequential per-channel sample stream.
// One pooled word per channel is emitted for every POOL_SIZE accepted samples.
module pool_layer #(
  parameter int    INPUT_SIZE   = 16,
  parameter int    POOL_SIZE    = 4,
  parameter int    WORD_SIZE    = 16,
  parameter int    N_SIZE       = 12,
  parameter int    NUM_CHANNELS = 4,
  parameter string MODE         = "avg",
  parameter int    MULTIPLIER   = ((1 << N_SIZE) + POOL_SIZE / 2) / POOL_SIZE
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  output logic                              ready_o,
  input  logic                              valid_i,
  input  logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [NUM_CHANNELS*WORD_SIZE-1:0] data_r_o,
  output logic                              last_o
);

  localparam int NUM_WIN = INPUT_SIZE / POOL_SIZE;
  localparam int CNT_W   = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
  localparam int ACC_W   = 2 * WORD_SIZE;
  localparam int SH_W    = ACC_W - N_SIZE;
  localparam bit IS_AVG  = (MODE == "avg");
  localparam bit IS_MAX  = (MODE == "max");

  localparam logic signed [WORD_SIZE-1:0] MULT_W   = WORD_SIZE'(MULTIPLIER);
  localparam logic signed [WORD_SIZE-1:0] WORD_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic signed [WORD_SIZE-1:0] WORD_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic signed [ACC_W-1:0]     ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0]     ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};

  if (!(IS_AVG || IS_MAX)) begin : g_mode_check
    $error("pool_layer: MODE must be \"avg\" or \"max\"");
  end
  if (POOL_SIZE < 1 || (INPUT_SIZE % POOL_SIZE) != 0) begin : g_size_check
    $error("pool_layer: INPUT_SIZE must be a non-zero multiple of POOL_SIZE");
  end

  typedef enum logic {eBUSY, eDONE} state_e;

  state_e                 state;
  logic [CNT_W-1:0]       sample_cnt;
  logic [WIN_W-1:0]       win_cnt;
  logic signed [ACC_W-1:0]     acc_q [NUM_CHANNELS];
  logic signed [ACC_W-1:0]     acc_d [NUM_CHANNELS];
  logic signed [WORD_SIZE-1:0] res_d [NUM_CHANNELS];

  logic acc;
  logic out_fire;
  logic first_smp;
  logic last_smp;
  logic done_win;

  assign ready_o   = (state == eBUSY) | ready_i;
  assign acc       = valid_i & ready_o;
  assign out_fire  = valid_o & ready_i;
  assign first_smp = (sample_cnt == '0);
  assign last_smp  = (sample_cnt == CNT_W'(POOL_SIZE - 1));
  assign done_win  = acc & last_smp;

  // Next accumulator value and the window result derived from it, so the
  // completing sample is folded into the word loaded on the same edge.
  always_comb begin
    logic signed [WORD_SIZE-1:0] smp;
    logic signed [WORD_SIZE-1:0] cur_max;
    logic signed [ACC_W-1:0]     prod;
    logic        [ACC_W:0]       wide;
    logic signed [ACC_W-1:0]     nxt;
    logic signed [SH_W-1:0]      shifted;
    smp     = '0;
    cur_max = '0;
    prod    = '0;
    wide    = '0;
    nxt     = '0;
    shifted = '0;
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      acc_d[c] = '0;
      res_d[c] = '0;
    end
    for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
      smp = data_r_i[c*WORD_SIZE +: WORD_SIZE];
      if (IS_MAX) begin
        cur_max = acc_q[c][WORD_SIZE-1:0];
        if (first_smp || (smp > cur_max)) begin
          nxt = {{WORD_SIZE{smp[WORD_SIZE-1]}}, smp};
        end else begin
          nxt = acc_q[c];
        end
        acc_d[c] = nxt;
        res_d[c] = nxt[WORD_SIZE-1:0];
      end else begin
        prod = smp * MULT_W;
        if (first_smp) begin
          nxt = prod;
        end else begin
          wide = {acc_q[c][ACC_W-1], acc_q[c]} + {prod[ACC_W-1], prod};
          if (wide[ACC_W] != wide[ACC_W-1]) begin
            nxt = wide[ACC_W] ? ACC_MIN : ACC_MAX;
          end else begin
            nxt = wide[ACC_W-1:0];
          end
        end
        acc_d[c] = nxt;
        // Dropping the low N_SIZE bits is an arithmetic shift toward -inf.
        shifted = nxt[ACC_W-1:N_SIZE];
        if (!shifted[SH_W-1] && (|shifted[SH_W-2:WORD_SIZE-1])) begin
          res_d[c] = WORD_MAX;
        end else if (shifted[SH_W-1] && !(&shifted[SH_W-2:WORD_SIZE-1])) begin
          res_d[c] = WORD_MIN;
        end else begin
          res_d[c] = shifted[WORD_SIZE-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state      <= eBUSY;
      sample_cnt <= '0;
      win_cnt    <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      data_r_o   <= '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      if (acc) begin
        sample_cnt <= last_smp ? '0 : sample_cnt + CNT_W'(1);
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
          acc_q[c] <= acc_d[c];
        end
      end
      if (done_win) begin
        win_cnt <= (win_cnt == WIN_W'(NUM_WIN - 1)) ? '0 : win_cnt + WIN_W'(1);
        for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
          data_r_o[c*WORD_SIZE +: WORD_SIZE] <= res_d[c];
        end
        last_o  <= (win_cnt == WIN_W'(NUM_WIN - 1));
        state   <= eDONE;
        valid_o <= 1'b1;
      end else if (out_fire) begin
        state   <= eBUSY;
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_layer.sv
// Scoreboard bench for pool_layer: avg and max windows, saturation,
// backpressure, mid-window reset and single-sample windows.
module tb_pool_layer;

  localparam int W  = 16;
  localparam int NC = 2;
  localparam int BW = W * NC;

  typedef struct packed {
    logic [BW-1:0] data;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic a_ready_o, a_valid_i, a_valid_o, a_ready_i, a_last_o;
  logic m_ready_o, m_valid_i, m_valid_o, m_ready_i, m_last_o;
  logic p_ready_o, p_valid_i, p_valid_o, p_ready_i, p_last_o;
  logic [BW-1:0] a_data_i, a_data_o, m_data_i, m_data_o, p_data_i, p_data_o;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  pool_layer #(.INPUT_SIZE(8), .POOL_SIZE(4), .WORD_SIZE(W), .N_SIZE(12),
               .NUM_CHANNELS(NC), .MODE("avg"), .MULTIPLIER(1024)) u_avg (
    .clk_i(clk), .reset_i(rst), .ready_o(a_ready_o), .valid_i(a_valid_i),
    .data_r_i(a_data_i), .valid_o(a_valid_o), .ready_i(a_ready_i),
    .data_r_o(a_data_o), .last_o(a_last_o));

  pool_layer #(.INPUT_SIZE(8), .POOL_SIZE(4), .WORD_SIZE(W), .N_SIZE(12),
               .NUM_CHANNELS(NC), .MODE("max")) u_max (
    .clk_i(clk), .reset_i(rst), .ready_o(m_ready_o), .valid_i(m_valid_i),
    .data_r_i(m_data_i), .valid_o(m_valid_o), .ready_i(m_ready_i),
    .data_r_o(m_data_o), .last_o(m_last_o));

  pool_layer #(.INPUT_SIZE(3), .POOL_SIZE(1), .WORD_SIZE(W), .N_SIZE(12),
               .NUM_CHANNELS(NC), .MODE("avg"), .MULTIPLIER(4096)) u_p1 (
    .clk_i(clk), .reset_i(rst), .ready_o(p_ready_o), .valid_i(p_valid_i),
    .data_r_i(p_data_i), .valid_o(p_valid_o), .ready_i(p_ready_i),
    .data_r_o(p_data_o), .last_o(p_last_o));

  function automatic logic [BW-1:0] pk(input int c1, input int c0);
    return {W'(c1), W'(c0)};
  endfunction

  // Reference: Q4.12 product sum clamped to 32 bits, floor by 2^12, clamp to 16 bits.
  function automatic logic [W-1:0] avg_ref(input int d [4], input int mult);
    longint sum = 0;
    longint p;
    longint q;
    for (int i = 0; i < 4; i++) begin
      p   = longint'(d[i]) * longint'(mult);
      sum = (i == 0) ? p : sum + p;
      if (sum > 64'sd2147483647)  sum = 64'sd2147483647;
      if (sum < -64'sd2147483648) sum = -64'sd2147483648;
    end
    q = sum >>> 12;
    if (q > 32767)  q = 32767;
    if (q < -32768) q = -32768;
    return q[W-1:0];
  endfunction

  function automatic logic rdy(input int which);
    case (which)
      0:       return a_ready_o;
      1:       return m_ready_o;
      default: return p_ready_o;
    endcase
  endfunction

  // Presents one sample and returns on the falling edge after it was accepted.
  task automatic send(input int which, input int d0, input int d1, output int waited);
    waited = 0;
    case (which)
      0:       begin a_valid_i = 1'b1; a_data_i = {W'(d1), W'(d0)}; end
      1:       begin m_valid_i = 1'b1; m_data_i = {W'(d1), W'(d0)}; end
      default: begin p_valid_i = 1'b1; p_data_i = {W'(d1), W'(d0)}; end
    endcase
    #1;
    while (!rdy(which) && waited < 50) begin
      @(negedge clk); #1;
      waited++;
    end
    n_vec++;
    if (waited >= 50) begin
      n_err++;
      $display("FAIL send_timeout dut%0d: ready_o low for %0d cycles, want high within 50", which, waited);
    end
    @(negedge clk);
    case (which)
      0:       a_valid_i = 1'b0;
      1:       m_valid_i = 1'b0;
      default: p_valid_i = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_valid_i = 1'b0; m_valid_i = 1'b0; p_valid_i = 1'b0;
    a_ready_i = 1'b1; m_ready_i = 1'b1; p_ready_i = 1'b1;
    a_data_i = '0; m_data_i = '0; p_data_i = '0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({a_valid_o, a_last_o, m_valid_o, m_last_o, p_valid_o, p_last_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, want 000000",
               {a_valid_o, a_last_o, m_valid_o, m_last_o, p_valid_o, p_last_o});
    end
    n_vec++;
    if (a_data_o !== '0 || m_data_o !== '0 || p_data_o !== '0) begin
      n_err++;
      $display("FAIL reset_data: got %h %h %h, want all zero", a_data_o, m_data_o, p_data_o);
    end
    a_ready_i = 1'b0; m_ready_i = 1'b0; p_ready_i = 1'b0;
    #1;
    n_vec++;
    if ({a_ready_o, m_ready_o, p_ready_o} !== 3'b111) begin
      n_err++;
      $display("FAIL reset_ready: got %b, want 111", {a_ready_o, m_ready_o, p_ready_o});
    end
    a_ready_i = 1'b1; m_ready_i = 1'b1; p_ready_i = 1'b1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_avg_basic();
    int   wt;
    exp_t e;
    int   c0 [8] = '{4096, 4096, 4096, 4096, 0, 0, 8192, 8192};
    int   c1 [8] = '{-4096, -4096, -4096, -4096, 100, 200, 300, 400};
    sb.push_back('{pk(-4096, 4096), 1'b0});
    sb.push_back('{pk(250, 4096), 1'b1});
    for (int i = 0; i < 8; i++) begin
      send(0, c0[i], c1[i], wt);
      #1;
      n_vec++;
      if (i % 4 != 3) begin
        if (a_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL avg_basic_early s%0d: valid_o=%b, want 0", i, a_valid_o);
        end
      end else begin
        e = sb.pop_front();
        if (a_valid_o !== 1'b1 || a_data_o !== e.data || a_last_o !== e.last) begin
          n_err++;
          $display("FAIL avg_basic s%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   i, a_valid_o, a_data_o, a_last_o, e.data, e.last);
        end
      end
    end
  endtask

  task automatic test_avg_saturation();
    int   wt;
    exp_t e;
    sb.push_back('{pk(-32768, 32767), 1'b0});
    sb.push_back('{pk(32767, -32768), 1'b1});
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (w == 0) send(0, 32767, -32768, wt);
        else        send(0, -32768, 32767, wt);
      end
      #1;
      e = sb.pop_front();
      n_vec++;
      if (a_valid_o !== 1'b1 || a_data_o !== e.data || a_last_o !== e.last) begin
        n_err++;
        $display("FAIL avg_sat w%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 w, a_valid_o, a_data_o, a_last_o, e.data, e.last);
      end
    end
  endtask

  task automatic test_avg_random();
    int   wt;
    exp_t e;
    int   d0 [4];
    int   d1 [4];
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 4; i++) begin
        d0[i] = int'($urandom_range(65535)) - 32768;
        d1[i] = int'($urandom_range(65535)) - 32768;
      end
      sb.push_back('{{avg_ref(d1, 1024), avg_ref(d0, 1024)}, (w % 2 == 1)});
      for (int i = 0; i < 4; i++) send(0, d0[i], d1[i], wt);
      #1;
      e = sb.pop_front();
      n_vec++;
      if (a_valid_o !== 1'b1 || a_data_o !== e.data || a_last_o !== e.last) begin
        n_err++;
        $display("FAIL avg_rand w%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                 w, a_valid_o, a_data_o, a_last_o, e.data, e.last);
      end
    end
  endtask

  task automatic test_backpressure();
    int   wt;
    exp_t e;
    @(negedge clk);
    a_ready_i = 1'b0;
    sb.push_back('{pk(25, 2500), 1'b0});
    sb.push_back('{pk(200, 1000), 1'b1});
    send(0, 1000, 10, wt);
    send(0, 2000, 20, wt);
    send(0, 3000, 30, wt);
    send(0, 4000, 40, wt);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (a_valid_o !== 1'b1 || a_data_o !== e.data || a_last_o !== e.last) begin
      n_err++;
      $display("FAIL bp_result: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
               a_valid_o, a_data_o, a_last_o, e.data, e.last);
    end
    a_valid_i = 1'b1;
    a_data_i  = pk(80, 400);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if (a_ready_o !== 1'b0 || a_valid_o !== 1'b1 || a_data_o !== e.data || a_last_o !== e.last) begin
        n_err++;
        $display("FAIL bp_hold c%0d: got rdy=%b v=%b d=%h l=%b, want rdy=0 v=1 d=%h l=%b",
                 i, a_ready_o, a_valid_o, a_data_o, a_last_o, e.data, e.last);
      end
    end
    a_ready_i = 1'b1;
    #1;
    n_vec++;
    if (a_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release: ready_o=%b, want 1", a_ready_o);
    end
    @(negedge clk);
    a_valid_i = 1'b0;
    #1;
    n_vec++;
    if (a_valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL bp_drain: valid_o=%b, want 0", a_valid_o);
    end
    send(0, 800, 160, wt);
    send(0, 1200, 240, wt);
    send(0, 1600, 320, wt);
    #1;
    e = sb.pop_front();
    n_vec++;
    if (a_valid_o !== 1'b1 || a_data_o !== e.data || a_last_o !== e.last) begin
      n_err++;
      $display("FAIL bp_next: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
               a_valid_o, a_data_o, a_last_o, e.data, e.last);
    end
  endtask

  task automatic test_reset_mid();
    int   wt;
    exp_t e;
    @(negedge clk);
    send(0, 7000, -7000, wt);
    send(0, 7000, -7000, wt);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (a_valid_o !== 1'b0 || a_data_o !== '0 || a_last_o !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_clear: got v=%b d=%h l=%b, want v=0 d=0 l=0",
               a_valid_o, a_data_o, a_last_o);
    end
    sb.push_back('{pk(-2048, 2048), 1'b0});
    for (int i = 0; i < 4; i++) begin
      send(0, 2048, -2048, wt);
      #1;
      if (i < 3) begin
        n_vec++;
        if (a_valid_o !== 1'b0) begin
          n_err++;
          $display("FAIL midreset_early s%0d: valid_o=%b, want 0", i, a_valid_o);
        end
      end
    end
    e = sb.pop_front();
    n_vec++;
    if (a_valid_o !== 1'b1 || a_data_o !== e.data || a_last_o !== e.last) begin
      n_err++;
      $display("FAIL midreset_result: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
               a_valid_o, a_data_o, a_last_o, e.data, e.last);
    end
  endtask

  task automatic test_max();
    int   wt;
    exp_t e;
    int   c0 [8] = '{-4096, 12288, 8192, 0, -5, -3, -9, -7};
    int   c1 [8] = '{-1, -2, -3, -4, -32768, 32767, 0, 5};
    sb.push_back('{pk(-1, 12288), 1'b0});
    sb.push_back('{pk(32767, -3), 1'b1});
    for (int i = 0; i < 8; i++) begin
      send(1, c0[i], c1[i], wt);
      #1;
      if (i % 4 == 3) begin
        e = sb.pop_front();
        n_vec++;
        if (m_valid_o !== 1'b1 || m_data_o !== e.data || m_last_o !== e.last) begin
          n_err++;
          $display("FAIL max s%0d: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   i, m_valid_o, m_data_o, m_last_o, e.data, e.last);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int   wt;
    exp_t e;
    int   c0 [6];
    int   c1 [6];
    c0[0] = 100;   c1[0] = -32768;
    c0[1] = -200;  c1[1] = 0;
    c0[2] = 32767; c1[2] = 5;
    for (int i = 3; i < 6; i++) begin
      c0[i] = int'($urandom_range(65535)) - 32768;
      c1[i] = int'($urandom_range(65535)) - 32768;
    end
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{pk(c1[i], c0[i]), (i % 3 == 2)});
      send(2, c0[i], c1[i], wt);
      #1;
      e = sb.pop_front();
      n_vec++;
      if (wt != 0 || p_valid_o !== 1'b1 || p_data_o !== e.data || p_last_o !== e.last) begin
        n_err++;
        $display("FAIL pool1 s%0d: got wait=%0d v=%b d=%h l=%b, want wait=0 v=1 d=%h l=%b",
                 i, wt, p_valid_o, p_data_o, p_last_o, e.data, e.last);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active at 200000, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_avg_basic();
    test_avg_saturation();
    test_avg_random();
    test_backpressure();
    test_reset_mid();
    test_max();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool_layer.md
Name: pool_layer

Overview:
- Parametrised successor to the global-average layer: windowed pooling over a sequential per-channel stream, in average or max mode.
- Each input frame of INPUT_SIZE samples is split into INPUT_SIZE/POOL_SIZE non-overlapping windows, and the block emits one pooled word per channel per window.
- With POOL_SIZE=INPUT_SIZE it reduces to global pooling.
- Sits between a conv/activation stage and the next layer, using the codebase's valid-ready handshake on both sides.

Parameters:
- INPUT_SIZE, 16, samples per channel per frame; must be a multiple of POOL_SIZE.
- POOL_SIZE, 4, samples per window, >=1.
- WORD_SIZE, 16, signed data width, Qm.n.
- N_SIZE, 12, fractional bits n.
- NUM_CHANNELS, 4, parallel channels packed in the data buses.
- MODE, "avg", "avg" or "max"; elaborated at compile time, and any other value is an elaboration error.
- MULTIPLIER, round(2^N_SIZE/POOL_SIZE), signed WORD_SIZE representation of 1/POOL_SIZE, used only in avg mode.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- ready_o  out  1  block can accept a sample this cycle.
- valid_i  in  1  upstream sample valid.
- data_r_i  in  NUM_CHANNELS*WORD_SIZE  signed samples; channel i occupies bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE].
- valid_o  out  1  pooled result valid.
- ready_i  in  1  downstream can accept.
- data_r_o  out  NUM_CHANNELS*WORD_SIZE  pooled results, registered, same packing as data_r_i.
- last_o  out  1  qualifies valid_o; set on the final window of a frame.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state=eBUSY, sample counter=0, window counter=0.
  - valid_o=0, last_o=0, data_r_o=0.
  - All accumulators cleared.
- Reset mid-window discards the partial window and the pending output. The next accepted sample is sample 0 of a new frame.
- States:
  - eBUSY: accumulating, no output pending.
  - eDONE: output register holds a result, valid_o=1.
- Handshake signals:
  - ready_o = (state==eBUSY) | ready_i. This is helpful-consumer behaviour: a sample can be taken in the same cycle the output is drained.
  - acc = valid_i & ready_o.
  - out_fire = valid_o & ready_i.
- Sample counter (0..POOL_SIZE-1):
  - Increments on acc; wraps to 0 after POOL_SIZE-1.
  - An accepted sample at count 0 re-initialises the window.
- Window counter (0..INPUT_SIZE/POOL_SIZE-1):
  - Increments on each window completion; wraps to 0 after the last window.
- Window completion = acc with sample counter == POOL_SIZE-1. On completion, on the same clock edge:
  - data_r_o <= combined result of the window.
  - last_o <= (window counter == last index).
  - state <= eDONE.
- Latency: valid_o rises the cycle after the accept of the last sample in the window.
- Transitions:
  - eBUSY -> eDONE on completion.
  - eDONE -> eBUSY on out_fire without a simultaneous completion.
  - eDONE stays eDONE if !ready_i, or on out_fire with a simultaneous completion (only possible when POOL_SIZE=1); the new result is loaded.
- In eDONE with !ready_i: ready_o=0, no samples accepted, and data_r_o/last_o are held stable.
- avg arithmetic, per channel:
  - prod = data × MULTIPLIER, 2*WORD_SIZE bits signed, Q(2m).(2n).
  - Window first sample: sum <= prod; otherwise sum <= sum + prod, saturated to the 2*WORD_SIZE signed range.
  - Output = sum arithmetic-shifted right by N_SIZE, saturated to the WORD_SIZE signed range (truncation toward -inf, no rounding).
- max arithmetic, per channel:
  - First sample loads the running max.
  - Later samples replace it when strictly greater (signed compare).
  - Output = running max; MULTIPLIER is unused.
- Channels are fully independent; no cross-channel interaction.
- Upstream must hold data_r_i stable while valid_i=1 and ready_o=0.

Test Plan:
- avg, Q4.12, POOL_SIZE=4, INPUT_SIZE=8, MULTIPLIER=1024, ready_i=1:
  - Stimulus: samples 4096,4096,4096,4096 then 0,0,8192,8192.
  - Response: outputs 4096 (last_o=0) then 4096 (last_o=1); each valid_o 1 cycle after the 4th accept.
- max, same sizes:
  - Stimulus: channel 0 = -4096,12288,8192,0; channel 1 = -1,-2,-3,-4.
  - Response: channel 0 = 12288, channel 1 = -1.
- Saturation, avg:
  - Stimulus: four samples of 0x7FFF, then four samples of 0x8000.
  - Response: 0x7FFF, then 0x8000; no wrap-around.
- Backpressure:
  - Stimulus: ready_i=0 for 5 cycles after a window completes, with valid_i=1 throughout.
  - Response: ready_o=0, data_r_o stable and no samples lost; on ready_i=1, output drained and next sample accepted in the same cycle.
- Reset mid-window:
  - Stimulus: accept 2 samples, assert reset_i for 1 cycle, then send 4 samples of 2048.
  - Response: after reset, valid_o=0 and data_r_o=0; the next output is 2048 with last_o=0.
- POOL_SIZE=1, avg, INPUT_SIZE=3:
  - Stimulus: stream 3 samples with ready_i=1 and valid_i=1 continuously.
  - Response: one output per cycle, MULTIPLIER=4096 so outputs equal the inputs, last_o set on the 3rd output.
